// File: rtl/layer_pingpong_arbiter.sv
// Ping-pong owner of two inter-layer feature RAM banks between a producer
// and a consumer layer.
//
// Ports:
//   clock, reset (async, active-low)
//   enable                     : allow new producer frames to start
//   prod_done / cons_done      : one-cycle end-of-frame pulses
//   prod_* / cons_*            : each layer's dual-port address and controls
//   bank0_* / bank1_*          : routed address and controls per bank
//   prod_enable / prod_reset   : producer run enable, active-low layer reset
//   cons_enable / cons_reset   : consumer run enable, active-low layer reset
//   cons_bank_sel              : bank whose q the consumer takes (0 = bank0)
//   frames_done                : completed consumer frames, wrapping
module layer_pingpong_arbiter #(
  parameter int ADDR_WIDTH      = 11,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       prod_done,
  input  logic                       cons_done,
  input  logic [ADDR_WIDTH-1:0]      prod_addr_a,
  input  logic [ADDR_WIDTH-1:0]      prod_addr_b,
  input  logic                       prod_rden_a,
  input  logic                       prod_rden_b,
  input  logic                       prod_wren_a,
  input  logic                       prod_wren_b,
  input  logic [ADDR_WIDTH-1:0]      cons_addr_a,
  input  logic [ADDR_WIDTH-1:0]      cons_addr_b,
  input  logic                       cons_rden_a,
  input  logic                       cons_rden_b,
  input  logic                       cons_wren_a,
  input  logic                       cons_wren_b,
  output logic [ADDR_WIDTH-1:0]      bank0_addr_a,
  output logic [ADDR_WIDTH-1:0]      bank0_addr_b,
  output logic [ADDR_WIDTH-1:0]      bank1_addr_a,
  output logic [ADDR_WIDTH-1:0]      bank1_addr_b,
  output logic                       bank0_rden_a,
  output logic                       bank0_rden_b,
  output logic                       bank0_wren_a,
  output logic                       bank0_wren_b,
  output logic                       bank1_rden_a,
  output logic                       bank1_rden_b,
  output logic                       bank1_wren_a,
  output logic                       bank1_wren_b,
  output logic                       prod_enable,
  output logic                       prod_reset,
  output logic                       cons_enable,
  output logic                       cons_reset,
  output logic                       cons_bank_sel,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done
);

  typedef enum logic [1:0] {
    P_IDLE,
    P_RST,
    P_RUN
  } p_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RST,
    C_RUN
  } c_state_t;

  localparam int BW = 2 * ADDR_WIDTH + 4;

  p_state_t   p_state;
  c_state_t   c_state;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       prod_bank;
  logic       cons_bank;
  logic       prod_fin;
  logic       cons_fin;

  assign prod_fin = (p_state == P_RUN) && prod_done;
  assign cons_fin = (c_state == C_RUN) && cons_done;

  // The two finishing layers always own different banks, so the
  // set and the clear never hit the same bit.
  always_comb begin
    full_nxt = full;
    if (cons_fin) full_nxt[cons_bank] = 1'b0;
    if (prod_fin) full_nxt[prod_bank] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) full <= 2'b00;
    else        full <= full_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_state     <= P_IDLE;
      prod_bank   <= 1'b0;
      prod_enable <= 1'b0;
      prod_reset  <= 1'b0;
    end else begin
      unique case (p_state)
        P_IDLE: begin
          prod_enable <= 1'b0;
          if (enable && !full[prod_bank]) begin
            p_state    <= P_RST;
            prod_reset <= 1'b0;
          end else begin
            prod_reset <= 1'b1;
          end
        end
        P_RST: begin
          p_state     <= P_RUN;
          prod_enable <= 1'b1;
          prod_reset  <= 1'b1;
        end
        P_RUN: begin
          if (prod_done) begin
            p_state     <= P_IDLE;
            prod_enable <= 1'b0;
            prod_bank   <= ~prod_bank;
          end
        end
        default: begin
          p_state     <= P_IDLE;
          prod_enable <= 1'b0;
          prod_reset  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_state     <= C_IDLE;
      cons_bank   <= 1'b0;
      cons_enable <= 1'b0;
      cons_reset  <= 1'b0;
      frames_done <= '0;
    end else begin
      unique case (c_state)
        C_IDLE: begin
          cons_enable <= 1'b0;
          if (full[cons_bank]) begin
            c_state    <= C_RST;
            cons_reset <= 1'b0;
          end else begin
            cons_reset <= 1'b1;
          end
        end
        C_RST: begin
          c_state     <= C_RUN;
          cons_enable <= 1'b1;
          cons_reset  <= 1'b1;
        end
        C_RUN: begin
          if (cons_done) begin
            c_state     <= C_IDLE;
            cons_enable <= 1'b0;
            cons_bank   <= ~cons_bank;
            frames_done <= frames_done + 1'b1;
          end
        end
        default: begin
          c_state     <= C_IDLE;
          cons_enable <= 1'b0;
          cons_reset  <= 1'b1;
        end
      endcase
    end
  end

  assign cons_bank_sel = cons_bank;

  logic [BW-1:0] prod_bus;
  logic [BW-1:0] cons_bus;
  logic [BW-1:0] bank0_bus;
  logic [BW-1:0] bank1_bus;
  logic          p_own0, p_own1;
  logic          c_own0, c_own1;

  assign prod_bus = {prod_addr_a, prod_addr_b,
                     prod_rden_a, prod_rden_b,
                     prod_wren_a, prod_wren_b};
  assign cons_bus = {cons_addr_a, cons_addr_b,
                     cons_rden_a, cons_rden_b,
                     cons_wren_a, cons_wren_b};

  // prod_enable / cons_enable are high exactly in the RUN states.
  assign p_own0 = prod_enable && !prod_bank;
  assign p_own1 = prod_enable &&  prod_bank;
  assign c_own0 = cons_enable && !cons_bank;
  assign c_own1 = cons_enable &&  cons_bank;

  always_comb begin
    bank0_bus = '0;
    unique case (1'b1)
      p_own0:  bank0_bus = prod_bus;
      c_own0:  bank0_bus = cons_bus;
      default: bank0_bus = '0;
    endcase
  end

  always_comb begin
    bank1_bus = '0;
    unique case (1'b1)
      p_own1:  bank1_bus = prod_bus;
      c_own1:  bank1_bus = cons_bus;
      default: bank1_bus = '0;
    endcase
  end

  assign {bank0_addr_a, bank0_addr_b,
          bank0_rden_a, bank0_rden_b,
          bank0_wren_a, bank0_wren_b} = bank0_bus;
  assign {bank1_addr_a, bank1_addr_b,
          bank1_rden_a, bank1_rden_b,
          bank1_wren_a, bank1_wren_b} = bank1_bus;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset) begin
      assert (!(prod_enable && cons_enable &&
                prod_bank == cons_bank))
        else $error("both layers own bank %0d", prod_bank);
    end
  end
`endif

endmodule

// File: tb/tb_layer_pingpong_arbiter.sv
// Bench for layer_pingpong_arbiter: directed steps plus random traffic,
// checked against a frame-count reference model.
module tb_layer_pingpong_arbiter;

  localparam int AW = 11;
  localparam int FW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          prod_done = 1'b0;
  logic          cons_done = 1'b0;
  logic [AW-1:0] prod_addr_a, prod_addr_b;
  logic          prod_rden_a, prod_rden_b;
  logic          prod_wren_a, prod_wren_b;
  logic [AW-1:0] cons_addr_a, cons_addr_b;
  logic          cons_rden_a, cons_rden_b;
  logic          cons_wren_a, cons_wren_b;
  logic [AW-1:0] bank0_addr_a, bank0_addr_b;
  logic [AW-1:0] bank1_addr_a, bank1_addr_b;
  logic          bank0_rden_a, bank0_rden_b;
  logic          bank0_wren_a, bank0_wren_b;
  logic          bank1_rden_a, bank1_rden_b;
  logic          bank1_wren_a, bank1_wren_b;
  logic          prod_enable, prod_reset;
  logic          cons_enable, cons_reset;
  logic          cons_bank_sel;
  logic [FW-1:0] frames_done;

  layer_pingpong_arbiter #(
    .ADDR_WIDTH(AW),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .prod_done(prod_done), .cons_done(cons_done),
    .prod_addr_a(prod_addr_a), .prod_addr_b(prod_addr_b),
    .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
    .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
    .cons_addr_a(cons_addr_a), .cons_addr_b(cons_addr_b),
    .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
    .cons_wren_a(cons_wren_a), .cons_wren_b(cons_wren_b),
    .bank0_addr_a(bank0_addr_a), .bank0_addr_b(bank0_addr_b),
    .bank1_addr_a(bank1_addr_a), .bank1_addr_b(bank1_addr_b),
    .bank0_rden_a(bank0_rden_a), .bank0_rden_b(bank0_rden_b),
    .bank0_wren_a(bank0_wren_a), .bank0_wren_b(bank0_wren_b),
    .bank1_rden_a(bank1_rden_a), .bank1_rden_b(bank1_rden_b),
    .bank1_wren_a(bank1_wren_a), .bank1_wren_b(bank1_wren_b),
    .prod_enable(prod_enable), .prod_reset(prod_reset),
    .cons_enable(cons_enable), .cons_reset(cons_reset),
    .cons_bank_sel(cons_bank_sel), .frames_done(frames_done)
  );

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  // Reference model: frames produced/consumed so far, plus each layer's
  // phase (0 idle, 1 in layer reset, 2 running). fresh marks the
  // interval after reset before the first clock edge.
  int produced, consumed;
  int p_ph, c_ph;
  bit fresh;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    produced = 0;
    consumed = 0;
    p_ph = 0;
    c_ph = 0;
    fresh = 1'b1;
  endtask

  task automatic model_edge();
    int pend, np, nc, npr, nco;
    pend = produced - consumed;
    np = p_ph; nc = c_ph; npr = produced; nco = consumed;
    if (p_ph == 2 && prod_done) begin npr++; np = 0; end
    else if (p_ph == 1) np = 2;
    else if (p_ph == 0 && enable && pend < 2) np = 1;
    if (c_ph == 2 && cons_done) begin nco++; nc = 0; end
    else if (c_ph == 1) nc = 2;
    else if (c_ph == 0 && pend > 0) nc = 1;
    p_ph = np; c_ph = nc; produced = npr; consumed = nco;
    fresh = 1'b0;
  endtask

  function automatic logic [25:0] exp_bank(input int b);
    logic [25:0] pb, cb;
    pb = {prod_addr_a, prod_addr_b, prod_rden_a, prod_rden_b,
          prod_wren_a, prod_wren_b};
    cb = {cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b,
          cons_wren_a, cons_wren_b};
    if (p_ph == 2 && produced % 2 == b) return pb;
    if (c_ph == 2 && consumed % 2 == b) return cb;
    return '0;
  endfunction

  task automatic check_all();
    chk("prod_enable", prod_enable, p_ph == 2);
    chk("prod_reset", prod_reset, !fresh && p_ph != 1);
    chk("cons_enable", cons_enable, c_ph == 2);
    chk("cons_reset", cons_reset, !fresh && c_ph != 1);
    chk("cons_bank_sel", cons_bank_sel, consumed % 2);
    chk("frames_done", frames_done, consumed % 256);
    chk("bank0", {bank0_addr_a, bank0_addr_b, bank0_rden_a,
                  bank0_rden_b, bank0_wren_a, bank0_wren_b},
        exp_bank(0));
    chk("bank1", {bank1_addr_a, bank1_addr_b, bank1_rden_a,
                  bank1_rden_b, bank1_wren_a, bank1_wren_b},
        exp_bank(1));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic rand_bus();
    prod_addr_a = AW'($urandom); prod_addr_b = AW'($urandom);
    cons_addr_a = AW'($urandom); cons_addr_b = AW'($urandom);
    {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = 4'($urandom);
    {cons_rden_a, cons_rden_b, cons_wren_a, cons_wren_b} = 4'($urandom);
  endtask

  initial begin
    bit ok;
    model_reset();
    rand_bus();
    #12;
    check_all();
    chk("rst_prod_reset", prod_reset, 1'b0);
    chk("rst_frames", frames_done, 8'd0);

    // 1: first producer frame on bank0
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;
    step();
    chk("t1_prod_rst_low", prod_reset, 1'b0);
    step();
    chk("t1_prod_run", {prod_enable, prod_reset}, 2'b11);
    prod_wren_a = 1'b1;
    #1;
    chk("t1_b0_wren_a", bank0_wren_a, 1'b1);
    chk("t1_b1_ctl", {bank1_rden_a, bank1_rden_b,
                      bank1_wren_a, bank1_wren_b}, 4'b0);
    for (int i = 0; i < 3; i++) begin rand_bus(); step(); end

    // 2: handoff, both layers run on opposite banks
    prod_done = 1'b1;
    step();
    prod_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      rand_bus();
      step();
      ok = (p_ph == 2 && c_ph == 2);
    end
    chk("t2_both_run", ok, 1'b1);
    cons_addr_a = 11'h155;
    prod_addr_a = 11'h2AA;
    #1;
    chk("t2_b0_addr_a", bank0_addr_a, 11'h155);
    chk("t2_b1_addr_a", bank1_addr_a, 11'h2AA);
    chk("t2_sel", cons_bank_sel, 1'b0);
    step();

    // 3: producer fills bank1 and waits for the consumer
    prod_done = 1'b1;
    step();
    prod_done = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_bus(); step(); end
    chk("t3_prod_wait", prod_enable, 1'b0);
    cons_done = 1'b1;
    step();
    cons_done = 1'b0;
    chk("t3_frames", frames_done, 8'd1);
    step();
    chk("t3_prod_rst", prod_reset, 1'b0);
    step();
    chk("t3_prod_run", prod_enable, 1'b1);

    // 4: simultaneous done pulses
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      rand_bus();
      step();
      ok = (p_ph == 2 && c_ph == 2);
    end
    chk("t4_both_run", ok, 1'b1);
    prod_done = 1'b1;
    cons_done = 1'b1;
    step();
    prod_done = 1'b0;
    cons_done = 1'b0;
    chk("t4_frames", frames_done, 8'd2);
    for (int i = 0; i < 6; i++) begin rand_bus(); step(); end

    // 5: reset during consumer run with both banks full
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      ok = (c_ph == 2 && produced - consumed == 2);
      if (!ok) begin
        prod_done = (p_ph == 2);
        rand_bus();
        step();
      end
    end
    prod_done = 1'b0;
    chk("t5_setup", ok, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_bus(); step(); end
    chk("t5_idle", {prod_enable, cons_enable}, 2'b00);

    // 6: random traffic through a frame counter wrap
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6000 && consumed < 262; i++) begin
      rand_bus();
      prod_done = (p_ph == 2) ? 1'($urandom % 2)
                              : ($urandom % 8 == 0);
      cons_done = (c_ph == 2) ? 1'($urandom % 2)
                              : ($urandom % 8 == 0);
      step();
      if (consumed == 256 && !ok) begin
        ok = 1'b1;
        chk("t6_wrap", frames_done, 8'd0);
      end
    end
    prod_done = 1'b0;
    cons_done = 1'b0;
    chk("t6_reached", consumed >= 262, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
